// File: rtl/mnist_pkg.sv
// mnist_pkg: shared constants and types for the binary MNIST datapath.
// Holds the conv2 input geometry, pixel type and read FSM states.
package mnist_pkg;

    localparam int NUM_CHANNELS = 8;
    localparam int FMAP2_WIDTH  = 13;
    localparam int FMAP2_HEIGHT = 13;

    typedef logic [NUM_CHANNELS-1:0] bin_pixel_t;

    typedef enum logic {
        IDLE,
        STREAM
    } rd_state_e;

endpackage

// File: rtl/fmap_stream_tx_if.sv
// fmap_stream_tx_if: pixel write handshake plus the conv2 output stream.
// master = pooling/conv2 side, slave = fmap_stream_tx.
interface fmap_stream_tx_if #(
    parameter int NUM_CHANNELS = 8
);

    logic                    wr_valid;
    logic [NUM_CHANNELS-1:0] wr_data;
    logic                    wr_ready;
    logic                    out_ready;
    logic [NUM_CHANNELS-1:0] pixel_out;
    logic                    valid_out;
    logic                    sof;
    logic                    eof;

    modport master (
        output wr_valid,
        output wr_data,
        output out_ready,
        input  wr_ready,
        input  pixel_out,
        input  valid_out,
        input  sof,
        input  eof
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  out_ready,
        output wr_ready,
        output pixel_out,
        output valid_out,
        output sof,
        output eof
    );

endinterface

// File: rtl/fmap_bank_ram.sv
// fmap_bank_ram: one frame of pixels, one write port and one read port.
// Read data is registered, so it appears one cycle after raddr.
module fmap_bank_ram #(
    parameter int DEPTH  = 169,
    parameter int DATA_W = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fmap_stream_tx.sv
// fmap_stream_tx: buffers a full feature map, then replays it gap-free.
// Define FMAP_PINGPONG_EN for two banks so writing overlaps streaming.
module fmap_stream_tx #(
    parameter int WIDTH        = mnist_pkg::FMAP2_WIDTH,
    parameter int HEIGHT       = mnist_pkg::FMAP2_HEIGHT,
    parameter int NUM_CHANNELS = mnist_pkg::NUM_CHANNELS
) (
    input  logic            clk,
    input  logic            rst_n,
    fmap_stream_tx_if.slave bus
);

    import mnist_pkg::*;

    localparam int N  = WIDTH * HEIGHT;
    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);
`ifdef FMAP_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    rd_state_e     state_q, state_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [NB-1:0] full_q, full_d;
    logic          wr_ready_q, wr_ready_d;
    logic          wr_bank_q, rd_bank_q;
    logic          wr_acc;
    logic          streaming;

    logic [NB-1:0][NUM_CHANNELS-1:0] rd_data;
    logic [NUM_CHANNELS-1:0]         rd_pix;

`ifdef FMAP_PINGPONG_EN
    logic wr_bank_d, rd_bank_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
        end
    end
`else
    assign wr_bank_q = 1'b0;
    assign rd_bank_q = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        full_d    = full_q;
`ifdef FMAP_PINGPONG_EN
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
`endif
        wr_acc = bus.wr_valid & wr_ready_q;

        if (wr_acc) begin
            if (wr_addr_q == LAST) begin
                wr_addr_d         = '0;
                full_d[wr_bank_q] = 1'b1;
`ifdef FMAP_PINGPONG_EN
                wr_bank_d         = ~wr_bank_q;
`endif
            end else begin
                wr_addr_d = wr_addr_q + 1'b1;
            end
        end

        // rd_addr_d feeds the RAM, so pixel k lands one cycle later
        unique case (state_q)
            IDLE: begin
                rd_addr_d = '0;
                if (full_q[rd_bank_q] && bus.out_ready) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (rd_addr_q == LAST) begin
                    rd_addr_d         = '0;
                    full_d[rd_bank_q] = 1'b0;
`ifdef FMAP_PINGPONG_EN
                    rd_bank_d = ~rd_bank_q;
                    if (!(full_q[~rd_bank_q] && bus.out_ready)) begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end else begin
                    rd_addr_d = rd_addr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef FMAP_PINGPONG_EN
        wr_ready_d = !full_d[wr_bank_d];
`else
        wr_ready_d = !full_d[0];
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            full_q     <= '0;
            wr_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            full_q     <= full_d;
            wr_ready_q <= wr_ready_d;
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_bank
        fmap_bank_ram #(
            .DEPTH (N),
            .DATA_W(NUM_CHANNELS)
        ) u_ram (
            .clk  (clk),
            .we   (wr_acc && (wr_bank_q == 1'(b))),
            .waddr(wr_addr_q),
            .wdata(bus.wr_data),
            .raddr(rd_addr_d),
            .rdata(rd_data[b])
        );
    end

    assign rd_pix    = rd_data[rd_bank_q];
    assign streaming = (state_q == STREAM);

    assign bus.wr_ready  = wr_ready_q;
    assign bus.valid_out = streaming;
    assign bus.sof       = streaming && (rd_addr_q == '0);
    assign bus.eof       = streaming && (rd_addr_q == LAST);
    assign bus.pixel_out = streaming ? rd_pix : '0;

endmodule

// File: tb/tb_fmap_stream_tx.sv
// tb_fmap_stream_tx: directed frames with hand-derived timing and data.
// Covers single, bursty, held-start, back-to-back and mid-stream reset.
module tb_fmap_stream_tx;

    localparam int N = 169;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fmap_stream_tx_if bus ();

    fmap_stream_tx dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int idle_bad = 0;

    logic [7:0] q_pix[$];
    bit         q_sof[$];
    bit         q_eof[$];
    int         q_edge[$];
    bit         rdy_log[int];

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // cycle following edge E is observed at the negedge where edge_n == E
    always @(negedge clk) begin
        rdy_log[edge_n] = bus.wr_ready;
        if (bus.valid_out === 1'b1) begin
            q_pix.push_back(bus.pixel_out);
            q_sof.push_back(bus.sof);
            q_eof.push_back(bus.eof);
            q_edge.push_back(edge_n);
        end else if (edge_n > 2 &&
                     (bus.pixel_out !== 8'h00 ||
                      bus.sof !== 1'b0 ||
                      bus.eof !== 1'b0)) begin
            idle_bad++;
        end
    end

    task automatic clear_q();
        q_pix.delete();
        q_sof.delete();
        q_eof.delete();
        q_edge.delete();
    endtask

    task automatic write_frame(input bit inv,
                               input bit bursty,
                               output int last_w);
        int a = 0;
        int guard = 0;
        bit acc;
        last_w = -1;
        while (a < N && guard < 4000) begin
            @(negedge clk);
            bus.wr_valid = bursty ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.wr_data  = inv ? ~8'(a) : 8'(a);
            acc = bus.wr_valid && bus.wr_ready;
            if (acc) last_w = edge_n + 1;
            @(posedge clk);
            if (acc) a++;
            guard++;
        end
        check("wr_count", a, N);
    endtask

    task automatic wait_items(input int n, input int limit);
        int t = 0;
        while (q_pix.size() < n && t < limit) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_frame(input string tag,
                               input int base,
                               input bit inv,
                               input int exp_start);
        int perr = 0;
        int cerr = 0;
        int ferr = 0;
        logic [7:0] e;
        check({tag, "_len"}, q_pix.size() >= base + N, 1);
        if (q_pix.size() < base + N) return;
        for (int k = 0; k < N; k++) begin
            e = inv ? ~8'(k) : 8'(k);
            if (q_pix[base+k] !== e) perr++;
            if (q_edge[base+k] != q_edge[base] + k) cerr++;
            if (q_sof[base+k] != (k == 0)) ferr++;
            if (q_eof[base+k] != (k == N - 1)) ferr++;
        end
        check({tag, "_start"}, q_edge[base], exp_start);
        check({tag, "_pix_err"}, perr, 0);
        check({tag, "_gap_err"}, cerr, 0);
        check({tag, "_flag_err"}, ferr, 0);
    endtask

    initial begin
        int lw;
        int lw2;
        int e0;
        int cnt;
        int target;

        bus.wr_valid  = 1'b0;
        bus.wr_data   = 8'h00;
        bus.out_ready = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_valid", bus.valid_out, 0);
        check("rst_sof", bus.sof, 0);
        check("rst_eof", bus.eof, 0);
        check("rst_pix", bus.pixel_out, 0);
        check("rst_wr_ready", bus.wr_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_wr_ready", bus.wr_ready, 1);

        // single frame, continuous writer
        bus.out_ready = 1'b1;
        clear_q();
        write_frame(1'b0, 1'b0, lw);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        wait_items(N, 400);
        check_frame("single", 0, 1'b0, lw + 1);
        check("single_count", q_pix.size(), N);

        // bursty writer
        clear_q();
        write_frame(1'b0, 1'b1, lw);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        wait_items(N, 400);
        check_frame("bursty", 0, 1'b0, lw + 1);
        check("bursty_count", q_pix.size(), N);

        // start held off by out_ready, then toggled mid-stream
        clear_q();
        bus.out_ready = 1'b0;
        write_frame(1'b1, 1'b0, lw);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("hold_no_out", q_pix.size(), 0);
        bus.out_ready = 1'b1;
        e0 = edge_n;
        repeat (120) begin
            @(negedge clk);
            bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
        wait_items(N, 400);
        check_frame("hold", 0, 1'b1, e0 + 1);
        check("hold_count", q_pix.size(), N);

        // second frame written while the first streams
        clear_q();
        write_frame(1'b0, 1'b0, lw);
        write_frame(1'b1, 1'b0, lw2);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        wait_items(2 * N, 600);
        check_frame("pp_f1", 0, 1'b0, lw + 1);
        check_frame("pp_f2", N, 1'b1, lw2 + 1);
        cnt = 0;
`ifdef FMAP_PINGPONG_EN
        check("pp_lw2", lw2, lw + N);
        for (int i = lw; i < lw2; i++) begin
            if (rdy_log[i] == 1'b0) cnt++;
        end
        check("pp_ready_drops", cnt, 0);
        if (q_edge.size() >= N + 1) begin
            check("pp_b2b", q_edge[N], q_edge[N-1] + 1);
        end
`else
        check("sb_lw2", lw2, lw + 2 * N + 1);
        for (int i = lw; i <= lw + N; i++) begin
            if (rdy_log[i] == 1'b1) cnt++;
        end
        check("sb_ready_blocked", cnt, 0);
        check("sb_ready_rise", rdy_log[lw+N+1], 1);
        if (q_edge.size() >= N + 1) begin
            check("sb_idle_gap", q_edge[N] > q_edge[N-1] + 1, 1);
        end
`endif

        // reset mid-stream at pixel 80
        clear_q();
        write_frame(1'b0, 1'b0, lw);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        target = lw + 1 + 80;
        cnt = 0;
        while (edge_n < target && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        check("mid_pix80", bus.pixel_out, 80);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", bus.valid_out, 0);
        check("mid_rst_sof", bus.sof, 0);
        check("mid_rst_eof", bus.eof, 0);
        check("mid_rst_pix", bus.pixel_out, 0);
        check("mid_rst_wr_ready", bus.wr_ready, 0);
        rst_n = 1'b1;
        clear_q();
        repeat (250) @(negedge clk);
        check("mid_no_resume", q_pix.size(), 0);
        write_frame(1'b1, 1'b0, lw);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        wait_items(N, 400);
        check_frame("fresh", 0, 1'b1, lw + 1);
        check("fresh_count", q_pix.size(), N);

        check("idle_outputs_zero", idle_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
